// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation codes, opcodes, operand selects,
// the ID/EX pipeline slot layout and the operand forwarding helper.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SLT  = 4'b1001
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Branch compare class, taken from funct3[2:1]
   localparam logic [1:0] BR_EQ  = 2'b00;
   localparam logic [1:0] BR_LT  = 2'b10;
   localparam logic [1:0] BR_LTU = 2'b11;

   typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
   typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR, B_ZERO} b_sel_e;

   typedef struct packed {
      logic            valid;
      alu_op_e         alu_op;
      a_sel_e          a_sel;
      b_sel_e          b_sel;
      logic            reg_write;
      logic            illegal;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } id_ex_t;

   // EX/MEM has priority over MEM/WB; x0 always keeps the register value
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [4:0]      src,
      input logic [XLEN-1:0] reg_val,
      input logic            em_we,
      input logic [4:0]      em_rd,
      input logic [XLEN-1:0] em_data,
      input logic            mw_we,
      input logic [4:0]      mw_rd,
      input logic [XLEN-1:0] mw_data);
      if (src != 5'd0 && em_we && em_rd == src)
         return em_data;
      else if (src != 5'd0 && mw_we && mw_rd == src)
         return mw_data;
      else
         return reg_val;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I opcode/funct decode into ALU code, operand selects,
// register-write enable and illegal flag.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   input  logic [4:0] rd_addr_i,
   output alu_op_e    alu_op_o,
   output a_sel_e     a_sel_o,
   output b_sel_e     b_sel_o,
   output logic       reg_write_o,
   output logic       illegal_o
);

   alu_op_e arith_op;
   logic    rw_raw;

   always_comb begin
      arith_op = ALU_ADD;
      unique case (funct3_i)
         3'b000:  arith_op = (opcode_i == OPC_OP && funct7_5_i) ? ALU_SUB : ALU_ADD;
         3'b001:  arith_op = ALU_SLL;
         3'b010:  arith_op = ALU_SLT;
         3'b011:  arith_op = ALU_SLTU;
         3'b100:  arith_op = ALU_XOR;
         3'b101:  arith_op = funct7_5_i ? ALU_SRA : ALU_SRL;
         3'b110:  arith_op = ALU_OR;
         default: arith_op = ALU_AND;
      endcase
   end

   always_comb begin
      alu_op_o  = ALU_ADD;
      a_sel_o   = A_RS1;
      b_sel_o   = B_IMM;
      rw_raw    = 1'b1;
      illegal_o = 1'b0;
      case (opcode_i)
         OPC_OP: begin
            alu_op_o = arith_op;
            b_sel_o  = B_RS2;
         end
         OPC_OP_IMM: alu_op_o = arith_op;
         OPC_LOAD:   ;
         OPC_STORE:  rw_raw = 1'b0;
         OPC_LUI:    a_sel_o = A_ZERO;
         OPC_AUIPC:  a_sel_o = A_PC;
         OPC_JAL, OPC_JALR: begin
            a_sel_o = A_PC;
            b_sel_o = B_FOUR;
         end
         OPC_BRANCH: begin
            b_sel_o = B_RS2;
            rw_raw  = 1'b0;
            case (funct3_i[2:1])
               BR_LT:   alu_op_o = ALU_SLT;
               BR_LTU:  alu_op_o = ALU_SLTU;
               default: alu_op_o = ALU_SUB;
            endcase
         end
         default: begin
            a_sel_o   = A_ZERO;
            b_sel_o   = B_ZERO;
            rw_raw    = 1'b0;
            illegal_o = 1'b1;
         end
      endcase
   end

   assign reg_write_o = rw_raw && (rd_addr_i != 5'd0);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the incoming instruction, holds it under
// stall, bubbles it on flush, and forwards operands into the ALU inputs.
module id_ex_stage
   import riscv_pkg::*;
(
   input  logic            CLOCK,
   input  logic            RESET,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7_5,
   input  logic [4:0]      id_rs1_addr,
   input  logic [4:0]      id_rs2_addr,
   input  logic [4:0]      id_rd_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_pc,
   input  logic            stall,
   input  logic            flush,
   input  logic            exmem_we,
   input  logic [4:0]      exmem_rd,
   input  logic [XLEN-1:0] exmem_data,
   input  logic            memwb_we,
   input  logic [4:0]      memwb_rd,
   input  logic [XLEN-1:0] memwb_data,
   output logic            ex_valid,
   output logic [XLEN-1:0] A,
   output logic [XLEN-1:0] B,
   output logic [3:0]      ALU_control,
   output logic [4:0]      ex_rd_addr,
   output logic            ex_reg_write,
   output logic [XLEN-1:0] ex_store_data,
   output logic [XLEN-1:0] ex_pc,
   output logic            ex_illegal
);

   id_ex_t          slot_d, slot_q;
   alu_op_e         dec_op;
   a_sel_e          dec_a_sel;
   b_sel_e          dec_b_sel;
   logic            dec_rw, dec_ill;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;

   alu_decoder u_dec (
      .opcode_i    (id_opcode),
      .funct3_i    (id_funct3),
      .funct7_5_i  (id_funct7_5),
      .rd_addr_i   (id_rd_addr),
      .alu_op_o    (dec_op),
      .a_sel_o     (dec_a_sel),
      .b_sel_o     (dec_b_sel),
      .reg_write_o (dec_rw),
      .illegal_o   (dec_ill)
   );

   always_comb begin
      slot_d = '0;
      if (flush)
         slot_d = '0;
      else if (stall)
         slot_d = slot_q;
      else if (id_valid) begin
         slot_d.valid     = 1'b1;
         slot_d.alu_op    = dec_op;
         slot_d.a_sel     = dec_a_sel;
         slot_d.b_sel     = dec_b_sel;
         slot_d.reg_write = dec_rw;
         slot_d.illegal   = dec_ill;
         slot_d.rs1_addr  = id_rs1_addr;
         slot_d.rs2_addr  = id_rs2_addr;
         slot_d.rd_addr   = id_rd_addr;
         slot_d.rs1_data  = id_rs1_data;
         slot_d.rs2_data  = id_rs2_data;
         slot_d.imm       = id_imm;
         slot_d.pc        = id_pc;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET)
         slot_q <= '0;
      else
         slot_q <= slot_d;
   end

   // Forwarding uses the current cycle's producers, so a stalled slot keeps refreshing
   assign rs1_fwd = fwd_sel(slot_q.rs1_addr, slot_q.rs1_data, exmem_we, exmem_rd,
                            exmem_data, memwb_we, memwb_rd, memwb_data);
   assign rs2_fwd = fwd_sel(slot_q.rs2_addr, slot_q.rs2_data, exmem_we, exmem_rd,
                            exmem_data, memwb_we, memwb_rd, memwb_data);

   always_comb begin
      A             = '0;
      B             = '0;
      ALU_control   = ALU_ADD;
      ex_reg_write  = 1'b0;
      ex_illegal    = 1'b0;
      ex_store_data = '0;
      if (slot_q.valid) begin
         case (slot_q.a_sel)
            A_RS1:   A = rs1_fwd;
            A_PC:    A = slot_q.pc;
            default: A = '0;
         endcase
         case (slot_q.b_sel)
            B_RS2:   B = rs2_fwd;
            B_IMM:   B = slot_q.imm;
            B_FOUR:  B = XLEN'(4);
            default: B = '0;
         endcase
         ALU_control   = slot_q.alu_op;
         ex_reg_write  = slot_q.reg_write;
         ex_illegal    = slot_q.illegal;
         ex_store_data = rs2_fwd;
      end
   end

   assign ex_valid   = slot_q.valid;
   assign ex_rd_addr = slot_q.rd_addr;
   assign ex_pc      = slot_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized run compared
// against an instruction-level reference model.
module tb_id_ex_stage;

   logic        CLOCK = 1'b0;
   logic        RESET, id_valid, id_funct7_5, stall, flush;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic        exmem_we, memwb_we;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_data, memwb_data;
   logic        ex_valid, ex_reg_write, ex_illegal;
   logic [31:0] A, B, ex_store_data, ex_pc;
   logic [3:0]  ALU_control;
   logic [4:0]  ex_rd_addr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLOCK = ~CLOCK;

   id_ex_stage dut (
      .CLOCK(CLOCK), .RESET(RESET), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_rs1_addr(id_rs1_addr),
      .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc), .stall(stall),
      .flush(flush), .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
      .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .ex_valid(ex_valid), .A(A), .B(B), .ALU_control(ALU_control),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
      .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
   );

   // Reference model: the instruction currently sitting in EX
   typedef struct packed {
      logic        valid;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f75;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm, pc;
   } m_inst_t;

   m_inst_t m;
   logic        e_valid, e_rw, e_ill;
   logic [31:0] e_a, e_b, e_sd;
   logic [3:0]  e_ctrl;

   function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
      if (r == 0) return v;
      if (exmem_we && exmem_rd == r) return exmem_data;
      if (memwb_we && memwb_rd == r) return memwb_data;
      return v;
   endfunction

   function automatic logic [3:0] arith_code(input logic [2:0] f3, input logic f75, input logic is_op);
      logic [3:0] tab [8];
      tab = '{4'd0, 4'd5, 4'd9, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
      if (f3 == 3'd0 && f75 && is_op) return 4'd1;
      if (f3 == 3'd5 && f75) return 4'd7;
      return tab[f3];
   endfunction

   task automatic compute_exp();
      e_valid = m.valid; e_a = 0; e_b = 0; e_ctrl = 0; e_rw = 0; e_ill = 0; e_sd = 0;
      if (m.valid) begin
         e_sd = m_fwd(m.rs2, m.d2);
         e_rw = 1'b1;
         case (m.opc)
            7'h33: begin e_a = m_fwd(m.rs1, m.d1); e_b = e_sd; e_ctrl = arith_code(m.f3, m.f75, 1'b1); end
            7'h13: begin e_a = m_fwd(m.rs1, m.d1); e_b = m.imm; e_ctrl = arith_code(m.f3, m.f75, 1'b0); end
            7'h03: begin e_a = m_fwd(m.rs1, m.d1); e_b = m.imm; end
            7'h23: begin e_a = m_fwd(m.rs1, m.d1); e_b = m.imm; e_rw = 0; end
            7'h37: e_b = m.imm;
            7'h17: begin e_a = m.pc; e_b = m.imm; end
            7'h6F, 7'h67: begin e_a = m.pc; e_b = 32'd4; end
            7'h63: begin
               e_a = m_fwd(m.rs1, m.d1); e_b = e_sd; e_rw = 0;
               e_ctrl = (m.f3 < 2) ? 4'd1 : (m.f3 < 6) ? 4'd9 : 4'd8;
            end
            default: begin e_ill = 1; e_rw = 0; end
         endcase
         if (m.rd == 0) e_rw = 0;
      end
   endtask

   task automatic tick();
      m_inst_t nxt;
      nxt = '{1'b1, id_opcode, id_funct3, id_funct7_5, id_rs1_addr, id_rs2_addr,
              id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_pc};
      if (RESET || flush) m = '0;
      else if (!stall) m = id_valid ? nxt : '0;
      @(posedge CLOCK);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [31:0] pc);
      id_valid = 1; id_opcode = opc; id_funct3 = f3; id_funct7_5 = f75;
      id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
   endtask

   task automatic clear_fwd();
      exmem_we = 0; exmem_rd = 0; exmem_data = 0;
      memwb_we = 0; memwb_rd = 0; memwb_data = 0;
   endtask

   task automatic test_reset();
      RESET = 1; stall = 0; flush = 0; clear_fwd();
      set_instr(7'h33, 0, 0, 1, 2, 3, 32'h1, 32'h2, 0, 32'h10);
      tick();
      RESET = 0;
      n_checks++;
      if (ex_valid !== 0 || A !== 0 || B !== 0 || ALU_control !== 0 || ex_reg_write !== 0 ||
          ex_illegal !== 0 || ex_store_data !== 0 || ex_rd_addr !== 0 || ex_pc !== 0) begin
         n_errors++;
         $display("FAIL reset: valid=%0b A=%h B=%h ctrl=%h rw=%0b ill=%0b sd=%h rd=%0d pc=%h, want all 0",
                  ex_valid, A, B, ALU_control, ex_reg_write, ex_illegal, ex_store_data, ex_rd_addr, ex_pc);
      end
   endtask

   task automatic test_decode();
      set_instr(7'h33, 3'd0, 1'b1, 1, 2, 3, 32'hA, 32'h3, 0, 32'h40);
      tick();
      n_checks++;
      if (ex_valid !== 1 || ALU_control !== 4'b0001 || A !== 32'hA || B !== 32'h3 || ex_reg_write !== 1) begin
         n_errors++;
         $display("FAIL sub: valid=%0b ctrl=%b A=%h B=%h rw=%0b, want 1 0001 a 3 1",
                  ex_valid, ALU_control, A, B, ex_reg_write);
      end
      set_instr(7'h13, 3'd5, 1'b1, 1, 0, 3, 32'hF0, 0, 32'd4, 0);
      tick();
      n_checks++;
      if (ALU_control !== 4'b0111 || B !== 32'd4) begin
         n_errors++;
         $display("FAIL srai: ctrl=%b B=%h, want 0111 4", ALU_control, B);
      end
      set_instr(7'h13, 3'd0, 1'b1, 1, 0, 3, 32'hF0, 0, 32'd4, 0);
      tick();
      n_checks++;
      if (ALU_control !== 4'b0000) begin
         n_errors++;
         $display("FAIL addi_f7: ctrl=%b, want 0000", ALU_control);
      end
      set_instr(7'h63, 3'd6, 1'b0, 1, 2, 5, 32'h7, 32'h8, 0, 0);
      tick();
      n_checks++;
      if (ALU_control !== 4'b1000 || ex_reg_write !== 0) begin
         n_errors++;
         $display("FAIL bltu: ctrl=%b rw=%0b, want 1000 0", ALU_control, ex_reg_write);
      end
      set_instr(7'h17, 3'd0, 1'b0, 0, 0, 6, 0, 0, 32'h2000, 32'h100);
      tick();
      n_checks++;
      if (A !== 32'h100 || B !== 32'h2000 || ALU_control !== 0 || ex_reg_write !== 1) begin
         n_errors++;
         $display("FAIL auipc: A=%h B=%h ctrl=%b rw=%0b, want 100 2000 0000 1", A, B, ALU_control, ex_reg_write);
      end
   endtask

   task automatic test_forwarding();
      set_instr(7'h33, 3'd0, 1'b0, 7, 0, 3, 32'h55, 0, 0, 0);
      exmem_we = 1; exmem_rd = 7; exmem_data = 32'h11;
      memwb_we = 1; memwb_rd = 7; memwb_data = 32'h22;
      tick();
      n_checks++;
      if (A !== 32'h11) begin
         n_errors++;
         $display("FAIL fwd_exmem: A=%h, want 11", A);
      end
      stall = 1; exmem_we = 0; #1;
      n_checks++;
      if (A !== 32'h22) begin
         n_errors++;
         $display("FAIL fwd_memwb: A=%h, want 22", A);
      end
      memwb_we = 0; #1;
      n_checks++;
      if (A !== 32'h55) begin
         n_errors++;
         $display("FAIL fwd_none: A=%h, want 55", A);
      end
      stall = 0;
      set_instr(7'h33, 3'd0, 1'b0, 0, 0, 3, 32'h66, 0, 0, 0);
      exmem_we = 1; exmem_rd = 0; memwb_we = 1; memwb_rd = 0;
      tick();
      n_checks++;
      if (A !== 32'h66) begin
         n_errors++;
         $display("FAIL fwd_x0: A=%h, want 66", A);
      end
      clear_fwd();
   endtask

   task automatic test_stall_flush();
      set_instr(7'h33, 3'd0, 1'b0, 1, 2, 9, 32'h5, 32'h6, 0, 32'h200);
      tick();
      stall = 1;
      set_instr(7'h33, 3'd4, 1'b0, 3, 4, 10, 32'h77, 32'h88, 0, 32'h204);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (ex_valid !== 1 || A !== 32'h5 || B !== 32'h6 || ALU_control !== 0 ||
             ex_rd_addr !== 9 || ex_pc !== 32'h200) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: A=%h B=%h ctrl=%b rd=%0d pc=%h, want 5 6 0000 9 200",
                     i, A, B, ALU_control, ex_rd_addr, ex_pc);
         end
      end
      flush = 1;
      tick();
      flush = 0; stall = 0;
      n_checks++;
      if (ex_valid !== 0 || A !== 0 || B !== 0 || ALU_control !== 0 || ex_reg_write !== 0 ||
          ex_illegal !== 0 || ex_store_data !== 0) begin
         n_errors++;
         $display("FAIL flush_stall: valid=%0b A=%h B=%h ctrl=%b rw=%0b sd=%h, want all 0",
                  ex_valid, A, B, ALU_control, ex_reg_write, ex_store_data);
      end
   endtask

   task automatic test_reset_illegal();
      set_instr(7'h13, 3'd6, 1'b0, 1, 0, 4, 32'h3, 0, 32'h9, 32'h300);
      tick();
      stall = 1; RESET = 1;
      tick();
      RESET = 0; stall = 0;
      n_checks++;
      if (ex_valid !== 0 || A !== 0 || B !== 0 || ALU_control !== 0) begin
         n_errors++;
         $display("FAIL reset_mid: valid=%0b A=%h B=%h ctrl=%b, want 0 0 0 0000", ex_valid, A, B, ALU_control);
      end
      set_instr(7'h7F, 3'd0, 1'b0, 1, 2, 4, 32'h3, 32'h4, 32'h9, 0);
      tick();
      n_checks++;
      if (ex_illegal !== 1 || ex_reg_write !== 0 || A !== 0 || B !== 0 || ALU_control !== 0) begin
         n_errors++;
         $display("FAIL illegal: ill=%0b rw=%0b A=%h B=%h ctrl=%b, want 1 0 0 0 0000",
                  ex_illegal, ex_reg_write, A, B, ALU_control);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] opcs [11];
      logic [2:0] f3;
      logic [6:0] opc;
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h7F, 7'h0B};
      for (int i = 0; i < 400; i++) begin
         opc = opcs[$urandom_range(0, 10)];
         f3  = 3'($urandom_range(0, 7));
         if (opc == 7'h63 && (f3 == 2 || f3 == 3)) f3 = 3'd0;
         set_instr(opc, f3, 1'($urandom()), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom(), $urandom());
         id_valid = ($urandom_range(0, 9) != 0);
         stall    = ($urandom_range(0, 6) == 0);
         flush    = ($urandom_range(0, 11) == 0);
         RESET    = ($urandom_range(0, 49) == 0);
         exmem_we = 1'($urandom()); exmem_rd = 5'($urandom_range(0, 3)); exmem_data = $urandom();
         memwb_we = 1'($urandom()); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom();
         tick();
         compute_exp();
         n_checks++;
         if (ex_valid !== e_valid || A !== e_a || B !== e_b || ALU_control !== e_ctrl ||
             ex_reg_write !== e_rw || ex_illegal !== e_ill) begin
            n_errors++;
            $display("FAIL rand[%0d]: got v=%0b A=%h B=%h c=%h rw=%0b il=%0b want v=%0b A=%h B=%h c=%h rw=%0b il=%0b",
                     i, ex_valid, A, B, ALU_control, ex_reg_write, ex_illegal,
                     e_valid, e_a, e_b, e_ctrl, e_rw, e_ill);
         end
         if (m.valid && !e_ill) begin
            n_checks++;
            if (ex_store_data !== e_sd || ex_rd_addr !== m.rd || ex_pc !== m.pc) begin
               n_errors++;
               $display("FAIL rand_pass[%0d]: sd=%h rd=%0d pc=%h, want %h %0d %h",
                        i, ex_store_data, ex_rd_addr, ex_pc, e_sd, m.rd, m.pc);
            end
         end
      end
      RESET = 0; stall = 0; flush = 0; clear_fwd();
   endtask

   initial begin
      m = '0;
      test_reset();
      test_decode();
      test_forwarding();
      test_stall_flush();
      test_reset_illegal();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
